// File: rtl/cache_mem_if.sv
// cache_mem_if: access, fill and flush bus between the cache controller and cache_mem_array.
interface cache_mem_if #(
  parameter int SETS  = 64,
  parameter int WAYS  = 2,
  parameter int TAG_W = 22,
  parameter int WORDS = 4
);
  localparam int SET_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  logic [SET_W-1:0]      set;
  logic [WAY_W-1:0]      way;
  logic                  enable;
  logic                  write_enable;
  logic                  val_write_enable;
  logic                  line_valid_i;
  logic [TAG_W-1:0]      line_tag_i;
  logic [32*WORDS-1:0]   line_i;
  logic [WORDS-1:0]      line_ww_enable_i;
  logic [TAG_W-1:0]      lookup_tag_i;
  logic                  flush_i;
  logic                  busy_o;
  logic [WAYS-1:0]       line_valid_o;
  logic [WAYS*TAG_W-1:0] line_tag_o;
  logic [32*WORDS-1:0]   line_o;
  logic                  hit_o;
  logic [WAY_W-1:0]      hit_way_o;
  logic [WAY_W-1:0]      victim_way_o;
  modport master (
    output set, way, enable, write_enable, val_write_enable, line_valid_i, line_tag_i,
           line_i, line_ww_enable_i, lookup_tag_i, flush_i,
    input  busy_o, line_valid_o, line_tag_o, line_o, hit_o, hit_way_o, victim_way_o
  );
  modport slave (
    input  set, way, enable, write_enable, val_write_enable, line_valid_i, line_tag_i,
           line_i, line_ww_enable_i, lookup_tag_i, flush_i,
    output busy_o, line_valid_o, line_tag_o, line_o, hit_o, hit_way_o, victim_way_o
  );
endinterface

// File: rtl/cache_mem_array.sv
// cache_mem_array: set-associative data/tag/valid storage with hit detection,
// per-set round-robin victim choice and a one-set-per-cycle invalidate-all flush.
module cache_mem_array #(
  parameter int SETS  = 64,
  parameter int WAYS  = 2,
  parameter int TAG_W = 22,
  parameter int WORDS = 4
) (
  input logic       clk,
  input logic       rst_n,
  cache_mem_if.slave bus
);
  localparam int SET_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t                    r_state, w_next;
  logic [SET_W-1:0]          r_cnt;
  logic [SETS-1:0][WAYS-1:0] r_valid;
  logic [SETS-1:0][WAY_W-1:0] r_ptr;
  logic [WORDS-1:0][31:0]    r_data [SETS][WAYS];
  logic [TAG_W-1:0]          r_tag  [SETS][WAYS];
  logic [WAYS-1:0]           r_valid_o;
  logic [WAYS*TAG_W-1:0]     r_tag_o, w_tag_rd;
  logic [32*WORDS-1:0]       r_line_o;
  logic [TAG_W-1:0]          r_lookup;
  logic [WAY_W-1:0]          r_victim, w_victim, w_hit_way;
  logic                      w_busy, w_acc, w_hit;
  assign w_busy = r_state == FLUSH;
  assign w_acc  = bus.enable && !w_busy;
  always_comb
    w_next = r_state == IDLE ? (bus.flush_i ? FLUSH : IDLE)
                             : (r_cnt == SET_W'(SETS-1) ? IDLE : FLUSH);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_busy ? r_cnt + 1'b1 : '0;
    end
  // Flush owns the valid/pointer state while busy, so no access can race it.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_valid <= '0;
      r_ptr   <= '0;
    end else if (w_busy) begin
      r_valid[r_cnt] <= '0;
      r_ptr[r_cnt]   <= '0;
    end else if (w_acc && (bus.write_enable || bus.val_write_enable)) begin
      r_valid[bus.set][bus.way] <= bus.line_valid_i;
      if (bus.write_enable && bus.line_valid_i && bus.way == r_ptr[bus.set])
        r_ptr[bus.set] <= r_ptr[bus.set] + 1'b1;
    end
  always_ff @(posedge clk)
    if (w_acc && bus.write_enable) begin
      r_tag[bus.set][bus.way] <= bus.line_tag_i;
      for (int k = 0; k < WORDS; k++)
        if (bus.line_ww_enable_i[k]) r_data[bus.set][bus.way][k] <= bus.line_i[32*k +: 32];
    end
  always_comb
    for (int i = 0; i < WAYS; i++) w_tag_rd[i*TAG_W +: TAG_W] = r_tag[bus.set][i];
  always_comb begin
    w_victim = r_ptr[bus.set];
    for (int i = WAYS-1; i >= 0; i--)
      if (!r_valid[bus.set][i]) w_victim = WAY_W'(i);
  end
  // Arrays are sampled before this edge's write lands, giving read-first behaviour.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_valid_o <= '0;
      r_tag_o   <= '0;
      r_line_o  <= '0;
      r_lookup  <= '0;
      r_victim  <= '0;
    end else if (w_acc) begin
      r_valid_o <= r_valid[bus.set];
      r_tag_o   <= w_tag_rd;
      r_line_o  <= r_data[bus.set][bus.way];
      r_lookup  <= bus.lookup_tag_i;
      r_victim  <= w_victim;
    end
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int i = WAYS-1; i >= 0; i--)
      if (r_valid_o[i] && r_tag_o[i*TAG_W +: TAG_W] == r_lookup) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(i);
      end
  end
  assign bus.busy_o       = w_busy;
  assign bus.line_valid_o = r_valid_o;
  assign bus.line_tag_o   = r_tag_o;
  assign bus.line_o       = r_line_o;
  assign bus.hit_o        = w_hit;
  assign bus.hit_way_o    = w_hit_way;
  assign bus.victim_way_o = r_victim;
endmodule

// File: tb/tb_cache_mem_array.sv
// tb_cache_mem_array: directed plus randomized checks of cache_mem_array against a
// behavioural array model (read-first outputs, lowest-way hit, victim rules, flush timing).
module tb_cache_mem_array;
  localparam int SETS = 64, WAYS = 2, TAG_W = 22, WORDS = 4;
  logic clk, rst_n;
  int checks = 0, errors = 0;
  cache_mem_if #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W), .WORDS(WORDS)) bus ();
  cache_mem_array #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  initial clk = 0;
  always #5 clk = ~clk;

  bit               m_valid [SETS][WAYS];
  logic [TAG_W-1:0] m_tag   [SETS][WAYS];
  bit               m_tk    [SETS][WAYS];
  logic [31:0]      m_data  [SETS][WAYS][WORDS];
  bit               m_dk    [SETS][WAYS][WORDS];
  int               m_ptr   [SETS];
  int               left;
  bit               e_valid [WAYS];
  logic [TAG_W-1:0] e_tag   [WAYS];
  bit               e_tk    [WAYS];
  logic [31:0]      e_line  [WORDS];
  bit               e_lk    [WORDS];
  logic [TAG_W-1:0] e_lookup;
  int               e_victim;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    for (int s = 0; s < SETS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0;
        m_tk[s][w] = 0;
        for (int k = 0; k < WORDS; k++) m_dk[s][w][k] = 0;
      end
    end
    for (int w = 0; w < WAYS; w++) begin e_valid[w] = 0; e_tag[w] = '0; e_tk[w] = 1; end
    for (int k = 0; k < WORDS; k++) begin e_line[k] = '0; e_lk[k] = 1; end
    e_lookup = '0;
    e_victim = 0;
    left = 0;
  endtask

  task automatic check();
    logic [WAYS-1:0] ev;
    int h;
    chk("busy", bus.busy_o, left > 0);
    for (int w = 0; w < WAYS; w++) ev[w] = e_valid[w];
    chk("line_valid", bus.line_valid_o, ev);
    for (int w = 0; w < WAYS; w++)
      if (e_tk[w]) chk("line_tag", bus.line_tag_o[w*TAG_W +: TAG_W], e_tag[w]);
    for (int k = 0; k < WORDS; k++)
      if (e_lk[k]) chk("line_word", bus.line_o[32*k +: 32], e_line[k]);
    h = 0;
    while (h < WAYS && !(e_valid[h] && e_tag[h] == e_lookup)) h++;
    chk("hit", bus.hit_o, h < WAYS);
    chk("hit_way", bus.hit_way_o, h < WAYS ? h : 0);
    chk("victim", bus.victim_way_o, e_victim);
  endtask

  task automatic cyc(input bit en, input bit we, input bit vwe, input int s, input int w,
                     input bit lv, input logic [TAG_W-1:0] tg, input logic [127:0] d,
                     input logic [WORDS-1:0] ww, input logic [TAG_W-1:0] lk, input bit fl);
    int v;
    bus.enable = en; bus.write_enable = we; bus.val_write_enable = vwe;
    bus.set = 6'(s); bus.way = 1'(w); bus.line_valid_i = lv; bus.line_tag_i = tg;
    bus.line_i = d; bus.line_ww_enable_i = ww; bus.lookup_tag_i = lk; bus.flush_i = fl;
    @(posedge clk);
    if (left > 0) begin
      for (int i = 0; i < WAYS; i++) m_valid[SETS-left][i] = 0;
      m_ptr[SETS-left] = 0;
      left--;
    end else begin
      if (en) begin
        for (int i = 0; i < WAYS; i++) begin
          e_valid[i] = m_valid[s][i]; e_tag[i] = m_tag[s][i]; e_tk[i] = m_tk[s][i];
        end
        for (int k = 0; k < WORDS; k++) begin e_line[k] = m_data[s][w][k]; e_lk[k] = m_dk[s][w][k]; end
        e_lookup = lk;
        v = 0;
        while (v < WAYS && m_valid[s][v]) v++;
        e_victim = v < WAYS ? v : m_ptr[s];
        if (we) begin
          for (int k = 0; k < WORDS; k++)
            if (ww[k]) begin m_data[s][w][k] = d[32*k +: 32]; m_dk[s][w][k] = 1; end
          m_tag[s][w] = tg; m_tk[s][w] = 1; m_valid[s][w] = lv;
          if (lv && w == m_ptr[s]) m_ptr[s] = (m_ptr[s] + 1) % WAYS;
        end else if (vwe) m_valid[s][w] = lv;
      end
      if (fl) left = SETS;
    end
    #1;
    check();
  endtask

  task automatic wr(input int s, input int w, input logic [TAG_W-1:0] tg, input logic [127:0] d,
                    input logic [WORDS-1:0] ww, input logic [TAG_W-1:0] lk);
    cyc(1, 1, 0, s, w, 1, tg, d, ww, lk, 0);
  endtask

  task automatic rd(input int s, input int w, input logic [TAG_W-1:0] lk);
    cyc(1, 0, 0, s, w, 0, '0, '0, '0, lk, 0);
  endtask

  localparam logic [127:0] D1 = 128'h1234_5678_ABCD_EF12_1337_4242_4343_6565;

  initial begin
    int bc;
    rst_n = 0;
    bus.enable = 0; bus.write_enable = 0; bus.val_write_enable = 0; bus.set = '0; bus.way = '0;
    bus.line_valid_i = 0; bus.line_tag_i = '0; bus.line_i = '0; bus.line_ww_enable_i = '0;
    bus.lookup_tag_i = '0; bus.flush_i = 0;
    mreset();
    #12;
    check();
    @(negedge clk) rst_n = 1;
    wr(0, 0, 22'h339977, D1, 4'hF, 22'h339977);
    chk("wr0_old_valid", bus.line_valid_o, 2'b00);
    rd(0, 0, 22'h339977);
    chk("rd0_valid", bus.line_valid_o, 2'b01);
    chk("rd0_tag", bus.line_tag_o[21:0], 22'h339977);
    chk("rd0_data", bus.line_o, D1);
    chk("rd0_hit", bus.hit_o, 1);
    chk("rd0_hit_way", bus.hit_way_o, 0);
    wr(0, 1, 22'h1338, 128'h3333, 4'hF, 22'h0);
    wr(0, 1, 22'h1338, 128'h9999, 4'b0001, 22'h0);
    rd(0, 1, 22'h1338);
    chk("ww_data", bus.line_o, 128'h9999);
    chk("ww_tag", bus.line_tag_o[43:22], 22'h1338);
    chk("ww_hit", bus.hit_o, 1);
    chk("ww_hit_way", bus.hit_way_o, 1);
    chk("ww_valid", bus.line_valid_o, 2'b11);
    wr(1, 0, 22'h5, 128'hABC, 4'hF, 22'h5);
    chk("rf_old_valid", bus.line_valid_o, 2'b00);
    rd(1, 0, 22'h5);
    chk("rf_new_valid", bus.line_valid_o, 2'b01);
    chk("rf_new_hit", bus.hit_o, 1);
    rd(2, 0, 22'h0);
    chk("empty_valid", bus.line_valid_o, 2'b00);
    chk("empty_hit", bus.hit_o, 0);
    chk("empty_victim", bus.victim_way_o, 0);
    rd(0, 0, 22'h0);
    chk("rr_start", bus.victim_way_o, 0);
    wr(0, 0, 22'h77, 128'h1, 4'hF, 22'h0);
    rd(0, 0, 22'h0);
    chk("rr_adv", bus.victim_way_o, 1);
    wr(0, 1, 22'h78, 128'h2, 4'hF, 22'h0);
    rd(0, 0, 22'h0);
    chk("rr_wrap", bus.victim_way_o, 0);
    cyc(0, 0, 0, 0, 0, 0, '0, '0, '0, '0, 1);
    bc = int'(bus.busy_o);
    for (int i = 0; i < SETS; i++) begin
      wr(0, 0, 22'h3FFFFF, 128'h5, 4'hF, 22'h3FFFFF);
      bc += int'(bus.busy_o);
    end
    chk("busy_cycles", bc, SETS);
    rd(0, 0, 22'h77);
    chk("flush_valid", bus.line_valid_o, 2'b00);
    chk("flush_hit", bus.hit_o, 0);
    wr(63, 1, 22'h42, 128'h42, 4'hF, 22'h42);
    cyc(0, 0, 0, 0, 0, 0, '0, '0, '0, '0, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, 0, '0, '0, '0, '0, 0);
    #3 rst_n = 0;
    #1 mreset();
    check();
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_line", bus.line_o, 128'h0);
    @(negedge clk) rst_n = 1;
    rd(63, 1, 22'h42);
    chk("rst_valid63", bus.line_valid_o, 2'b00);
    for (int i = 0; i < 400; i++) begin
      bit en, we, vwe, lv, fl;
      int s, w;
      en = ($urandom % 4) != 0;
      we = ($urandom % 3) == 0;
      vwe = ($urandom % 4) == 0;
      s = ($urandom % 8 == 0) ? int'($urandom % SETS) : int'($urandom % 4);
      w = int'($urandom % WAYS);
      lv = ($urandom % 4) != 0;
      if (!we && vwe && !m_tk[s][w]) lv = 0;
      fl = ($urandom % 120) == 0;
      cyc(en, we, vwe, s, w, lv, 22'h100 + 22'($urandom % 4),
          {$urandom, $urandom, $urandom, $urandom}, 4'($urandom), 22'h100 + 22'($urandom % 4), fl);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_mem_array.md
Name: cache_mem_array

Overview:
Parametrised set-associative cache storage: data, tag and valid arrays, plus tag compare, hit detection, a round-robin victim choice per set and a sequenced flush. It is the next-generation cache memory wrapper. It sits between the cache controller FSM and the physical arrays, and serves both lookup and line fill/update. Compared with the fixed 64-set/2-way wrapper, it adds hit logic, victim selection and invalidate-all.

Parameters:
SETS, 64, number of sets (power of two, >=2)
WAYS, 2, associativity (power of two, >=2)
TAG_W, 22, tag width in bits
WORDS, 4, 32-bit words per line
SET_W, $clog2(SETS), derived set index width
WAY_W, $clog2(WAYS), derived way index width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
set  in  SET_W  set index of access
way  in  WAY_W  way index for write / line_o select
enable  in  1  access strobe
write_enable  in  1  full write: data words, tag, valid
val_write_enable  in  1  valid-bit-only write
line_valid_i  in  1  valid bit to write
line_tag_i  in  TAG_W  tag to write
line_i  in  32*WORDS  line data; word k = bits [32k+31:32k]
line_ww_enable_i  in  WORDS  per-word write enable
lookup_tag_i  in  TAG_W  tag to compare on this access
flush_i  in  1  start invalidate-all
busy_o  out  1  flush in progress; accesses ignored
line_valid_o  out  WAYS  valid bits of the accessed set, all ways
line_tag_o  out  WAYS*TAG_W  tags of the accessed set; way w = bits [TAG_W*w +: TAG_W]
line_o  out  32*WORDS  data of the registered way in the accessed set
hit_o  out  1  some way is valid with tag == registered lookup tag
hit_way_o  out  WAY_W  lowest-index hitting way (0 when no hit)
victim_way_o  out  WAY_W  replacement way for the accessed set

Behaviour:
- Storage: data and tag arrays are not reset, so their contents are undefined until written. Valid bits and per-set round-robin pointers are flops, cleared asynchronously by rst_n=0.
- Reset values: all outputs 0, busy_o=0, FSM in IDLE.
- Access acceptance: an access is accepted when enable=1 and busy_o=0. Any other access is ignored, with no array change and outputs held.
- Write on accepted access with write_enable=1:
  - word k of data[set][way] is written iff line_ww_enable_i[k]=1;
  - tag[set][way] <= line_tag_i and valid <= line_valid_i unconditionally.
- Valid-only write: val_write_enable=1 with write_enable=0 updates only valid[set][way]. When both are high, write_enable dominates.
- Read: every accepted access, read or write, registers set, way and lookup_tag_i.
  - Outputs update on the following edge, i.e. 1-cycle latency.
  - Read-first: a same-cycle write to the same set returns pre-write contents.
  - Outputs hold until the next accepted access.
- Hit logic: hit_o and hit_way_o are combinational from the registered valid bits, tags and lookup tag. With multiple hits, the lowest way index wins.
- Victim selection: victim_way_o is registered per access.
  - It is the lowest-index invalid way of the set (pre-write state).
  - If all ways are valid, it is the set's round-robin pointer.
- Pointer advance: the pointer increments modulo WAYS when an accepted write_enable write with line_valid_i=1 targets way == pointer. It wraps WAYS-1 -> 0.
- Flush FSM, states IDLE and FLUSH:
  - IDLE and flush_i=1 -> FLUSH, counter=0, busy_o=1 from the next cycle.
  - In FLUSH, each cycle clears valid of all ways and the rr pointer of set counter, then counter++.
  - When counter==SETS-1 it clears that set and returns to IDLE. busy_o is high for exactly SETS cycles.
  - flush_i during FLUSH is ignored.
- Simultaneous flush_i and accepted access in IDLE: the access completes in that cycle and the flush begins next cycle, so the written valid bit is later cleared.
- Outputs are not changed by a flush; they still show the last access until a new access is accepted after busy_o falls.
- rst_n low at any time, including mid-flush: immediate return to IDLE, busy_o=0, all valids and pointers 0, outputs 0.

Test Plan:
- Reset, then write set 0 way 0 with tag 22'h339977, data 128'h1234_5678_ABCD_EF12_1337_4242_4343_6565, ww=4'hF, lookup 22'h339977; then read set 0 -> next cycle line_valid_o=2'b01, line_tag_o[21:0]=22'h339977, line_o=written data, hit_o=1, hit_way_o=0.
- Write set 0 way 1 with tag 'h1338, data 'h3333, ww=4'hF. Then rewrite way 1 with data 'h9999, ww=4'b0001. Read way 1 with lookup 'h1338 -> line_o='h9999, tag 'h1338, hit_o=1, hit_way_o=1, line_valid_o=2'b11.
- Same-cycle write then read, both to set 1: the write cycle's output shows the old valid 0; the following read shows the new contents. Read set 2 (never written) -> line_valid_o=0, hit_o=0, victim_way_o=0.
- Round-robin: set 0 fully valid, victim_way_o=0. Write way 0 valid -> victim 1. Write way 1 valid -> victim wraps to 0.
- Assert flush_i for 1 cycle -> busy_o high exactly 64 cycles, accesses ignored meanwhile. Afterwards read set 0 -> line_valid_o=0, hit_o=0.
- Pulse rst_n low at flush cycle 10 -> busy_o=0 immediately, all outputs 0, and a subsequent read of set 63 returns line_valid_o=0.
